// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: RISC-V byte-addressed load/store unit in front of a word-addressed dmem
// Ports: clk, rst_n (async, active low);
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : execute-side request
//   resp_valid/resp_err/resp_rdata : one-cycle response pulse, error flag, extended load data
//   wmem/rmem/mem_addr/store_data/load_data : dmem port (whole-word writes, 1-cycle read latency)
module lsu_dmem_ctrl #(
   parameter int ADDR_WIDTH = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [3:0]  wmem,
   output logic [4:0]  rmem,
   output logic [31:0] mem_addr,
   output logic [31:0] store_data,
   input  logic [31:0] load_data
);
   typedef enum logic [3:0] {IDLE, ERR, LD_ISSUE, LD_WAIT, ST_ISSUE, RMW_RD, RMW_WAIT, RMW_WR, RESP} state_t;
   state_t                state;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [15:0]           wdata_q;
   logic                  bad;
   logic [4:0]            rmem_req;
   logic [3:0]            lane_mask;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   logic [31:0]           widx_req, widx_q, ld_ext, wd_rep, merged;

   // illegal funct3, misaligned, or beyond the implemented word range
   assign bad = (req_funct3[2] ? (req_we || req_funct3[1]) : req_funct3[1:0] == 2'b11)
             || (req_funct3[1:0] == 2'b01 && req_addr[0])
             || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
             || (|req_addr[31:ADDR_WIDTH+2]);
   assign widx_req = {{(30-ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
   assign widx_q   = {{(30-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};
   // one-hot {LHU,LBU,LW,LH,LB}
   assign rmem_req = req_funct3[2] ? {req_funct3[0], ~req_funct3[0], 3'b000} : 5'b00001 << req_funct3[1:0];
   assign ld_b = load_data[{addr_q[1:0], 3'b000} +: 8];
   assign ld_h = addr_q[1] ? load_data[31:16] : load_data[15:0];
   assign ld_ext = f3_q == 3'b000 ? {{24{ld_b[7]}}, ld_b}
                 : f3_q == 3'b001 ? {{16{ld_h[15]}}, ld_h}
                 : f3_q == 3'b100 ? {24'b0, ld_b}
                 : f3_q == 3'b101 ? {16'b0, ld_h}
                 : load_data;
   // sub-word stores: replicate the data across lanes and splice only the masked lanes
   assign lane_mask = f3_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
   assign wd_rep = f3_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign merged[8*k +: 8] = lane_mask[k] ? wd_rep[8*k +: 8] : load_data[8*k +: 8];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         wmem       <= '0;
         rmem       <= '0;
         mem_addr   <= '0;
         store_data <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         wmem       <= '0;
         rmem       <= '0;
         mem_addr   <= '0;
         store_data <= '0;
         case (state)
            IDLE: if (req_valid) begin
               f3_q      <= req_funct3;
               addr_q    <= req_addr[ADDR_WIDTH+1:0];
               wdata_q   <= req_wdata[15:0];
               req_ready <= 1'b0;
               if (bad) begin
                  state      <= ERR;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (!req_we) begin
                  state    <= LD_ISSUE;
                  rmem     <= rmem_req;
                  mem_addr <= widx_req;
               end else if (req_funct3 == 3'b010) begin
                  state      <= ST_ISSUE;
                  wmem       <= 4'b1111;
                  mem_addr   <= widx_req;
                  store_data <= req_wdata;
               end else begin
                  state    <= RMW_RD;
                  rmem     <= 5'b00100;
                  mem_addr <= widx_req;
               end
            end
            LD_ISSUE: state <= LD_WAIT;
            LD_WAIT: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= ld_ext;
            end
            ST_ISSUE, RMW_WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= '0;
            end
            RMW_RD: state <= RMW_WAIT;
            RMW_WAIT: begin
               state      <= RMW_WR;
               wmem       <= lane_mask;
               mem_addr   <= widx_q;
               store_data <= merged;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
endmodule
